// File: rtl/adjust_repeat_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adjust_repeat_ctrl_pkg
// Description : Shared FSM state encoding and counter-width helper for the
//               hold-to-repeat adjust controller.
// Revision    : 1.0  initial release
// ============================================================================
package adjust_repeat_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_DELAY = 3'd2,
        ST_SLOW  = 3'd3,
        ST_FAST  = 3'd4
    } state_t;

    // Width needed to hold the largest reload value (period - 1), plus margin.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adjust_repeat_ctrl_rate_timer.sv
`default_nettype none
// ============================================================================
// Module      : adjust_repeat_ctrl_rate_timer
// Description : Loadable down-counter that parks at zero and flags it.
// Revision    : 1.0  initial release
// ============================================================================
module adjust_repeat_ctrl_rate_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/adjust_repeat_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adjust_repeat_ctrl
// Description : Hold-to-repeat set-button controller producing per-target
//               increment pulses merged with each target's natural carry.
// Revision    : 1.0  initial release
// ============================================================================
module adjust_repeat_ctrl
    import adjust_repeat_ctrl_pkg::*;
#(
    parameter int N_TGT         = 2,
    parameter int SEL_W         = 1,
    parameter int HOLD_DELAY    = 50,
    parameter int REPEAT_PERIOD = 20,
    parameter int FAST_AFTER    = 5,
    parameter int FAST_PERIOD   = 5
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             btn,
    input  logic [SEL_W-1:0] sel,
    input  logic [N_TGT-1:0] carry_in,
    output logic [N_TGT-1:0] up,
    output logic             busy
);

    localparam int CNT_W = cnt_width(HOLD_DELAY, REPEAT_PERIOD, FAST_PERIOD);
    localparam int REP_W = $clog2(FAST_AFTER + 1);

    localparam logic [CNT_W-1:0] C_HOLD_LD   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_FAST_LD   = CNT_W'(FAST_PERIOD - 1);
    localparam logic [REP_W-1:0] C_FAST_AFTER = REP_W'(FAST_AFTER);

    logic             r_meta;
    logic             r_bs;
    state_t           r_state;
    state_t           w_state_n;
    logic [SEL_W-1:0] r_tgt;
    logic [SEL_W-1:0] w_tgt_n;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_n;
    logic             r_pending;
    logic [N_TGT-1:0] r_up;

    logic             w_press;
    logic             w_sel_ok;
    logic             w_sel_match;
    logic             w_fire;
    logic             w_tmr_clear;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic [N_TGT-1:0] w_tgt_oh;
    logic             w_req;
    logic             w_carry_hit;
    logic             w_emit;
    logic             w_pend_n;
    logic [N_TGT-1:0] w_manual;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_bs   <= 1'b0;
        end else begin
            r_meta <= btn;
            r_bs   <= r_meta;
        end
    end

    // bs is about to rise: leave IDLE on the very edge that raises it.
    assign w_press     = r_meta & ~r_bs;
    assign w_sel_ok    = (int'(sel) < N_TGT);
    assign w_sel_match = (sel == r_tgt);

    always_comb begin
        w_tgt_oh = '0;
        for (int i = 0; i < N_TGT; i++) begin
            w_tgt_oh[i] = (int'(r_tgt) == i);
        end
    end

    adjust_repeat_ctrl_rate_timer #(
        .CNT_W (CNT_W)
    ) u_rate_timer (
        .clk     (ck),
        .rst     (reset),
        .i_clear (w_tmr_clear),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_zero  (w_tmr_zero)
    );

    always_comb begin
        w_state_n   = r_state;
        w_tgt_n     = r_tgt;
        w_rep_n     = r_rep;
        w_fire      = 1'b0;
        w_tmr_clear = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        if (r_state == ST_IDLE) begin
            if (w_press && w_sel_ok) begin
                w_state_n = ST_FIRST;
                w_tgt_n   = sel;
            end
        end else if (!r_bs || !w_sel_match) begin
            w_state_n   = ST_IDLE;
            w_tmr_clear = 1'b1;
            w_rep_n     = '0;
        end else begin
            case (r_state)
                ST_FIRST: begin
                    w_fire     = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_HOLD_LD;
                    w_state_n  = ST_DELAY;
                end
                ST_DELAY: begin
                    if (w_tmr_zero) begin
                        w_fire     = 1'b1;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = C_REPEAT_LD;
                        w_rep_n    = '0;
                        w_state_n  = ST_SLOW;
                    end
                end
                ST_SLOW: begin
                    if (w_tmr_zero) begin
                        w_fire     = 1'b1;
                        w_tmr_load = 1'b1;
                        w_rep_n    = r_rep + REP_W'(1);
                        if (w_rep_n == C_FAST_AFTER) begin
                            w_tmr_val = C_FAST_LD;
                            w_state_n = ST_FAST;
                        end else begin
                            w_tmr_val = C_REPEAT_LD;
                        end
                    end
                end
                ST_FAST: begin
                    if (w_tmr_zero) begin
                        w_fire     = 1'b1;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = C_FAST_LD;
                    end
                end
                default: begin
                    w_state_n   = ST_IDLE;
                    w_tmr_clear = 1'b1;
                    w_rep_n     = '0;
                end
            endcase
        end
    end

    // A manual pulse that meets a carry on the same target is deferred a cycle.
    assign w_req       = w_fire | r_pending;
    assign w_carry_hit = |(carry_in & w_tgt_oh);
    assign w_emit      = w_req & ~w_carry_hit;
    assign w_pend_n    = (w_fire & r_pending) | (w_req & w_carry_hit);
    assign w_manual    = {N_TGT{w_emit}} & w_tgt_oh;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tgt     <= '0;
            r_rep     <= '0;
            r_pending <= 1'b0;
            r_up      <= '0;
        end else begin
            r_state   <= w_state_n;
            r_tgt     <= w_tgt_n;
            r_rep     <= w_rep_n;
            r_pending <= w_pend_n;
            r_up      <= carry_in | w_manual;
        end
    end

    assign up   = r_up;
    assign busy = (r_state != ST_IDLE) | r_pending;

endmodule
`default_nettype wire

// File: tb/tb_adjust_repeat_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adjust_repeat_ctrl
// Description : Scoreboard bench for adjust_repeat_ctrl with directed presses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adjust_repeat_ctrl;

    logic       ck = 1'b0;
    logic       reset;
    logic       btn;
    logic [1:0] sel;
    logic [1:0] carry_in;
    logic [1:0] up;
    logic       busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } exp_t;

    exp_t exp_q[$];

    adjust_repeat_ctrl #(
        .N_TGT         (2),
        .SEL_W         (2),
        .HOLD_DELAY    (8),
        .REPEAT_PERIOD (4),
        .FAST_AFTER    (3),
        .FAST_PERIOD   (2)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .btn      (btn),
        .sel      (sel),
        .carry_in (carry_in),
        .up       (up),
        .busy     (busy)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    // Expected up pulses, kept sorted by cycle; same-cycle entries are OR-ed.
    task automatic push(input int c, input logic [1:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == c) begin
                exp_q[i].val = exp_q[i].val | v;
                return;
            end
            if (exp_q[i].cyc > c) begin
                exp_q.insert(i, e);
                return;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    always @(negedge ck) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_up cyc=%0d got=00 want=%b", exp_q[0].cyc, exp_q[0].val);
            void'(exp_q.pop_front());
        end
        if (up !== 2'b00) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_up cyc=%0d got=%b want=00", cyc, up);
            end else begin
                if (up !== exp_q[0].val) begin
                    errors++;
                    $display("FAIL up_value cyc=%0d got=%b want=%b", cyc, up, exp_q[0].val);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int c;
        int c2;
        int long_offs[9] = '{0, 8, 12, 16, 20, 22, 24, 26, 28};

        reset    = 1'b1;
        btn      = 1'b0;
        sel      = 2'd0;
        carry_in = 2'b00;
        tick(2);
        chk("reset_up", up, 2'b00);
        chk("reset_busy", {1'b0, busy}, 2'b00);
        reset = 1'b0;
        tick(2);

        // Short tap on target 0: single pulse, busy drops after release.
        c   = cyc;
        sel = 2'd0;
        btn = 1'b1;
        push(c + 3, 2'b01);
        tick(3);
        btn = 1'b0;
        tick(2);
        chk("tap_busy_high", {1'b0, busy}, 2'b01);
        tick(1);
        chk("tap_busy_low", {1'b0, busy}, 2'b00);
        tick(4);

        // Long hold on target 1: first, slow x3, then fast repeat.
        c   = cyc;
        sel = 2'd1;
        btn = 1'b1;
        foreach (long_offs[i]) push(c + 3 + long_offs[i], 2'b10);
        tick(15);
        chk("hold_busy", {1'b0, busy}, 2'b01);
        tick(15);
        btn = 1'b0;
        tick(6);
        chk("hold_busy_end", {1'b0, busy}, 2'b00);

        // Carry lands on the same cycle as the first repeat pulse.
        c   = cyc;
        sel = 2'd0;
        btn = 1'b1;
        push(c + 3, 2'b01);
        push(c + 11, 2'b01);
        push(c + 12, 2'b01);
        tick(10);
        carry_in = 2'b01;
        tick(1);
        carry_in = 2'b00;
        tick(1);
        btn = 1'b0;
        tick(6);
        chk("coll_busy_end", {1'b0, busy}, 2'b00);

        // Selection change mid-hold aborts; a fresh press on the new target restarts.
        c   = cyc;
        sel = 2'd0;
        btn = 1'b1;
        push(c + 3, 2'b01);
        tick(5);
        sel = 2'd1;
        tick(2);
        chk("abort_busy", {1'b0, busy}, 2'b00);
        tick(10);
        btn = 1'b0;
        tick(4);
        c2  = cyc;
        btn = 1'b1;
        push(c2 + 3, 2'b10);
        tick(4);
        btn = 1'b0;
        tick(6);

        // Out-of-range selection: no manual pulses, carries still pass through.
        sel = 2'd3;
        btn = 1'b1;
        tick(5);
        chk("inval_busy", {1'b0, busy}, 2'b00);
        carry_in = 2'b10;
        push(cyc + 1, 2'b10);
        tick(1);
        carry_in = 2'b00;
        tick(14);
        chk("inval_busy_late", {1'b0, busy}, 2'b00);
        btn = 1'b0;
        tick(4);

        // Asynchronous reset during a hold; only a new press restarts.
        c   = cyc;
        sel = 2'd0;
        btn = 1'b1;
        push(c + 3, 2'b01);
        tick(3);
        chk("pre_rst_busy", {1'b0, busy}, 2'b01);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_up", up, 2'b00);
        chk("async_rst_busy", {1'b0, busy}, 2'b00);
        tick(1);
        btn = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(6);
        chk("post_rst_busy", {1'b0, busy}, 2'b00);
        c   = cyc;
        btn = 1'b1;
        push(c + 3, 2'b01);
        tick(3);
        btn = 1'b0;
        tick(6);

        tick(2);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_up cyc=%0d got=00 want=%b", exp_q[0].cyc, exp_q[0].val);
            void'(exp_q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
